// File: rtl/wb_mem_seg_reg.sv
// rtl/wb_mem_seg_reg.sv - MEM/WB segment register with integrated dual-port data RAM
module wb_mem_seg_reg #(
    parameter int ADDR_BITS    = 12,
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clear,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    input  logic [2:0]  Funct3M,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [31:0] ResultM,
    input  logic [4:0]  RdM,
    input  logic        RegWriteM,
    input  logic        MemToRegM,
    output logic [31:0] ResultW,
    output logic [4:0]  RdW,
    output logic        RegWriteW,
    output logic        MemToRegW,
    output logic [31:0] LoadDataW,
    output logic        MisalignW,
    output logic        MemBusy,
    input  logic [31:0] A2,
    input  logic [31:0] WD2,
    input  logic [3:0]  WE2,
    output logic [31:0] RD2
);

    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic {IDLE, WAIT} state_t;

    logic [31:0]          mem_q [DEPTH];
    logic [31:0]          rd_pipe_q [READ_LATENCY];
    logic [31:0]          rd2_q;
    logic [ADDR_BITS-1:0] addr_a, addr_b;
    logic                 upd, mis, is_half, is_word;
    logic [3:0]           lane_mask, we_a;
    logic [31:0]          st_data;

    logic [31:0] result_q;
    logic [4:0]  rd_q;
    logic        regwrite_q, memtoreg_q, misalign_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic        upd_q, clr_q;
    logic [31:0] held_q, raw_eff, ext;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{A[31:ADDR_BITS+2], A2[31:ADDR_BITS+2], A2[1:0]};

    assign addr_a = A[ADDR_BITS+1:2];
    assign addr_b = A2[ADDR_BITS+1:2];
    assign upd    = en & ~MemBusy;

    always_comb begin
        is_half = (Funct3M == 3'b001) || (Funct3M == 3'b101);
        is_word = (Funct3M == 3'b010);
        mis     = (MemReadM | MemWriteM) & ((is_half & A[0]) | (is_word & (A[1:0] != 2'b00)));
        case (Funct3M[1:0])
            2'b00: begin
                lane_mask = 4'b0001 << A[1:0];
                st_data   = {4{WD[7:0]}};
            end
            2'b01: begin
                lane_mask = 4'b0011 << A[1:0];
                st_data   = {2{WD[15:0]}};
            end
            default: begin
                lane_mask = 4'b1111;
                st_data   = WD;
            end
        endcase
        we_a = (MemWriteM & upd & ~clear & ~mis) ? lane_mask : 4'b0000;
    end

    // Port B lanes are written first so a colliding port-A lane overrides them.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (WE2[i]) mem_q[addr_b][8*i +: 8] <= WD2[8*i +: 8];
            if (we_a[i]) mem_q[addr_a][8*i +: 8] <= st_data[8*i +: 8];
        end
        rd2_q        <= mem_q[addr_b];
        rd_pipe_q[0] <= mem_q[addr_a];
        for (int i = 1; i < READ_LATENCY; i++) begin
            rd_pipe_q[i] <= rd_pipe_q[i-1];
        end
    end

    assign RD2 = rd2_q;

    generate
        if (READ_LATENCY > 1) begin : g_fsm
            localparam logic [1:0] LAST = 2'(READ_LATENCY - 1);
            state_t     state_q, state_d;
            logic [1:0] cnt_q, cnt_d;
            logic       busy;

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q <= IDLE;
                    cnt_q   <= 2'd0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                end
            end

            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                busy    = 1'b0;
                case (state_q)
                    IDLE: begin
                        busy = MemReadM & en & ~clear & ~mis;
                        if (busy) begin
                            state_d = WAIT;
                            cnt_d   = 2'd1;
                        end
                    end
                    WAIT: begin
                        if (clear) begin
                            state_d = IDLE;
                            cnt_d   = 2'd0;
                        end else if (cnt_q < LAST) begin
                            busy = 1'b1;
                            if (en) cnt_d = cnt_q + 2'd1;
                        end else if (en) begin
                            state_d = IDLE;
                            cnt_d   = 2'd0;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end

            assign MemBusy = busy;
        end else begin : g_no_fsm
            assign MemBusy = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q   <= 32'd0;
            rd_q       <= 5'd0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            misalign_q <= 1'b0;
            funct3_q   <= 3'd0;
            off_q      <= 2'd0;
            upd_q      <= 1'b0;
            clr_q      <= 1'b0;
            held_q     <= 32'd0;
        end else begin
            upd_q  <= upd;
            clr_q  <= upd & clear;
            held_q <= raw_eff;
            if (upd) begin
                if (clear) begin
                    result_q   <= 32'd0;
                    rd_q       <= 5'd0;
                    regwrite_q <= 1'b0;
                    memtoreg_q <= 1'b0;
                    misalign_q <= 1'b0;
                    funct3_q   <= 3'd0;
                    off_q      <= 2'd0;
                end else begin
                    result_q   <= ResultM;
                    rd_q       <= RdM;
                    regwrite_q <= RegWriteM & ~(MemReadM & mis);
                    memtoreg_q <= MemToRegM;
                    misalign_q <= mis;
                    funct3_q   <= Funct3M;
                    off_q      <= A[1:0];
                end
            end
        end
    end

    // Stalled cycles replay the last raw word so LoadDataW stays frozen.
    always_comb begin
        raw_eff = held_q;
        if (upd_q) raw_eff = clr_q ? 32'd0 : rd_pipe_q[READ_LATENCY-1];
        ld_byte = raw_eff[{off_q, 3'b000} +: 8];
        ld_half = off_q[1] ? raw_eff[31:16] : raw_eff[15:0];
        case (funct3_q)
            3'b000:  ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ext = {24'd0, ld_byte};
            3'b001:  ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  ext = {16'd0, ld_half};
            default: ext = raw_eff;
        endcase
    end

    assign ResultW   = result_q;
    assign RdW       = rd_q;
    assign RegWriteW = regwrite_q;
    assign MemToRegW = memtoreg_q;
    assign MisalignW = misalign_q;
    assign LoadDataW = misalign_q ? 32'd0 : ext;

endmodule

// File: tb/tb_wb_mem_seg_reg.sv
// tb/tb_wb_mem_seg_reg.sv - scoreboard bench for wb_mem_seg_reg with a byte-level memory model
module tb_wb_mem_seg_reg;

    localparam int AB = 6;
    localparam int RL = 3;

    logic        clk = 1'b0, rst = 1'b1, en = 1'b0, clear = 1'b0;
    logic [31:0] A = '0, WD = '0, ResultM = '0;
    logic [2:0]  Funct3M = '0;
    logic        MemReadM = 1'b0, MemWriteM = 1'b0, RegWriteM = 1'b0, MemToRegM = 1'b0;
    logic [4:0]  RdM = '0;
    logic [31:0] ResultW, LoadDataW, RD2;
    logic [4:0]  RdW;
    logic        RegWriteW, MemToRegW, MisalignW, MemBusy;
    logic [31:0] A2 = '0, WD2 = '0;
    logic [3:0]  WE2 = '0;

    wb_mem_seg_reg #(.ADDR_BITS(AB), .READ_LATENCY(RL)) dut (
        .clk(clk), .rst(rst), .en(en), .clear(clear), .A(A), .WD(WD), .Funct3M(Funct3M),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .ResultM(ResultM), .RdM(RdM),
        .RegWriteM(RegWriteM), .MemToRegM(MemToRegM), .ResultW(ResultW), .RdW(RdW),
        .RegWriteW(RegWriteW), .MemToRegW(MemToRegW), .LoadDataW(LoadDataW),
        .MisalignW(MisalignW), .MemBusy(MemBusy), .A2(A2), .WD2(WD2), .WE2(WE2), .RD2(RD2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        rw;
        logic        m2r;
        logic        mis;
        logic [31:0] ld;
        logic        ldc;
    } exp_t;

    typedef struct {
        int          op;    // 0 alu, 1 load, 2 store
        logic [2:0]  f3;
        logic [31:0] a, wd, res;
        logic [4:0]  rd;
        logic        rw, m2r, clr, late;
    } txn_t;

    int         checks = 0;
    int         passes = 0;
    logic [7:0] memb [256];
    exp_t       q [$];
    exp_t       cur = '{default: '0, ldc: 1'b1};
    bit         upd_seen = 0, rst_seen = 0;

    task automatic check(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 1;
        endcase
    endfunction

    function automatic bit mis_of(input txn_t t);
        return (t.op != 0) && ((int'(t.a[7:0]) % size_of(t.f3)) != 0);
    endfunction

    function automatic logic [31:0] word_at(input int base);
        return {memb[base+3], memb[base+2], memb[base+1], memb[base]};
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] a);
        int b = int'(a[7:0]);
        logic [7:0]  by = memb[b];
        logic [15:0] hw = {memb[b|1], memb[b & 254]};
        case (f3)
            3'b000:  return {{24{by[7]}}, by};
            3'b100:  return {24'd0, by};
            3'b001:  return {{16{hw[15]}}, hw};
            3'b101:  return {16'd0, hw};
            default: return word_at(b - (b % 4));
        endcase
    endfunction

    function automatic txn_t mk(input int op, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        txn_t t;
        t.op = op; t.f3 = f3; t.a = a; t.wd = wd;
        t.res = $urandom; t.rd = 5'($urandom); t.rw = 1'($urandom); t.m2r = 1'($urandom);
        t.clr = 1'b0; t.late = 1'b0;
        return t;
    endfunction

    // Scoreboard monitor: pops one expectation per WB update, otherwise outputs must hold.
    always @(posedge clk) begin
        rst_seen = rst;
        upd_seen = !rst && en && !MemBusy;
    end

    always @(negedge clk) begin
        exp_t act, e;
        if (rst_seen) begin
            cur = '0;
            cur.ldc = 1'b1;
        end else if (upd_seen) begin
            if (q.size() == 0) check(1'b0, "sb_underflow", 128'd0, 128'd1);
            else cur = q.pop_front();
        end
        e = cur;
        if (!e.ldc) e.ld = 32'd0;
        act = {ResultW, RdW, RegWriteW, MemToRegW, MisalignW, e.ldc ? LoadDataW : 32'd0, e.ldc};
        check(act == e, "wb_outputs", 128'(act), 128'(e));
    end

    task automatic send(input txn_t t);
        int   bc = 0;
        bit   sawb = 0, acc = 0;
        exp_t e;
        A = t.a; WD = t.wd; Funct3M = t.f3; ResultM = t.res; RdM = t.rd;
        RegWriteM = t.rw; MemToRegM = t.m2r; clear = t.clr;
        MemReadM = (t.op == 1); MemWriteM = (t.op == 2);
        for (int g = 0; g < 60 && !acc; g++) begin
            en = ($urandom_range(0, 3) != 0);
            if (t.late && sawb) clear = 1'b1;
            #1;
            if (en && MemBusy) begin bc++; sawb = 1; end
            if (en && !MemBusy) begin
                acc = 1;
                e = '0;
                e.ldc = 1'b1;
                if (!clear) begin
                    e.res = t.res; e.rd = t.rd; e.m2r = t.m2r; e.mis = mis_of(t);
                    e.rw  = t.rw && !(t.op == 1 && e.mis);
                    if (t.op == 1) e.ld = e.mis ? 32'd0 : load_val(t.f3, t.a);
                    else e.ldc = e.mis;
                    if (t.op == 2 && !e.mis)
                        for (int k = 0; k < size_of(t.f3); k++)
                            memb[int'(t.a[7:0]) - (int'(t.a[7:0]) % size_of(t.f3)) + k] = t.wd[8*k +: 8];
                end
                q.push_back(e);
                if (!clear) check(bc == ((t.op == 1 && !mis_of(t)) ? RL - 1 : 0), "busy_cycles",
                                  128'(bc), 128'((t.op == 1 && !mis_of(t)) ? RL - 1 : 0));
            end
            @(negedge clk);
        end
        if (!acc) check(1'b0, "accept_timeout", 128'd0, 128'd1);
        clear = 1'b0;
    endtask

    task automatic stall(input int n);
        en = 1'b0;
        repeat (n) begin
            A = $urandom; WD = $urandom; ResultM = $urandom; clear = 1'($urandom);
            MemReadM = 1'($urandom); MemWriteM = 1'($urandom); Funct3M = 3'($urandom);
            @(negedge clk);
        end
        clear = 1'b0;
    endtask

    task automatic dbg_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
        A2 = a; WD2 = d; WE2 = we;
        @(negedge clk);
        WE2 = 4'b0000;
        for (int k = 0; k < 4; k++) if (we[k]) memb[int'(a[7:2]) * 4 + k] = d[8*k +: 8];
    endtask

    task automatic dbg_read_check(input logic [31:0] a);
        A2 = a; WE2 = 4'b0000;
        @(negedge clk);
        check(RD2 == word_at(int'(a[7:2]) * 4), "rd2", 128'(RD2), 128'(word_at(int'(a[7:2]) * 4)));
    endtask

    initial begin
        txn_t t;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check(MemBusy == 1'b0, "reset_busy", 128'(MemBusy), 128'd0);
        check(LoadDataW == 32'd0, "reset_loaddata", 128'(LoadDataW), 128'd0);

        for (int w = 0; w < 64; w++) dbg_write(32'(w * 4), $urandom, 4'hF);
        dbg_write(32'hFFFF_FF80, 32'hCAFE_F00D, 4'hF);
        dbg_read_check(32'h0000_0080);
        dbg_write(32'h84, 32'h1122_3344, 4'b0101);
        dbg_read_check(32'h84);

        send(mk(2, 3'b010, 32'h10, 32'h8000_00F1));
        send(mk(1, 3'b000, 32'h10, 32'h0));
        check(LoadDataW == 32'hFFFF_FFF1, "lb_sign", 128'(LoadDataW), 128'hFFFF_FFF1);
        send(mk(2, 3'b001, 32'h22, 32'h1234_ABCD));
        send(mk(1, 3'b010, 32'h20, 32'h0));
        check(LoadDataW[31:16] == 16'hABCD, "lw_upper_half", 128'(LoadDataW), 128'hABCD);
        send(mk(1, 3'b101, 32'h22, 32'h0));
        check(LoadDataW == 32'h0000_ABCD, "lhu", 128'(LoadDataW), 128'hABCD);
        send(mk(1, 3'b010, 32'h40, 32'h0));
        stall(3);
        t = mk(0, 3'b000, 32'h0, 32'h0);
        t.clr = 1'b1;
        send(t);
        check(ResultW == 32'd0 && LoadDataW == 32'd0, "clear_zero", 128'(ResultW), 128'd0);
        send(mk(2, 3'b010, 32'h41, 32'hDEAD_BEEF));
        check(MisalignW == 1'b1, "sw_misalign", 128'(MisalignW), 128'd1);
        send(mk(1, 3'b010, 32'h40, 32'h0));
        t = mk(1, 3'b001, 32'h43, 32'h0);
        t.rw = 1'b1;
        send(t);
        check(RegWriteW == 1'b0 && LoadDataW == 32'd0, "lh_misalign", 128'({RegWriteW, LoadDataW}), 128'd0);
        t = mk(1, 3'b010, 32'h44, 32'h0);
        t.late = 1'b1;
        send(t);

        A = 32'h40; Funct3M = 3'b010; MemReadM = 1'b1; MemWriteM = 1'b0; clear = 1'b0; en = 1'b1;
        #1;
        check(MemBusy == 1'b1, "busy_raise", 128'(MemBusy), 128'd1);
        @(negedge clk);
        rst = 1'b1; en = 1'b0; MemReadM = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check(MemBusy == 1'b0, "busy_after_rst", 128'(MemBusy), 128'd0);
        check(ResultW == 32'd0 && RdW == 5'd0 && LoadDataW == 32'd0, "outputs_after_rst",
              128'({ResultW, RdW, LoadDataW}), 128'd0);
        send(mk(1, 3'b010, 32'h40, 32'h0));

        for (int n = 0; n < 300; n++) begin
            int op = $urandom_range(0, 2);
            logic [2:0] f3s [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            logic [2:0] f3 = (op == 1) ? f3s[$urandom_range(0, 4)] :
                             (op == 2) ? f3s[$urandom_range(0, 2)] : 3'($urandom);
            logic [31:0] a = $urandom;
            int lo = int'(a[7:0]);
            if ($urandom_range(0, 3) != 0) a[7:0] = 8'(lo - lo % size_of(f3));
            t = mk(op, f3, a, $urandom);
            t.clr  = ($urandom_range(0, 9) == 0);
            t.late = ($urandom_range(0, 5) == 0);
            send(t);
            if ($urandom_range(0, 7) == 0) stall($urandom_range(1, 3));
        end

        stall(2);
        check(q.size() == 0, "sb_drained", 128'(q.size()), 128'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/wb_mem_seg_reg.md
# wb_mem_seg_reg

Parametrised write-back segment register with an integrated dual-port data RAM, and the successor of the fixed-latency WB register. It sits between the MEM and WB stages of the RISC-V pipeline. Beyond the MEM/WB control and result registers, it adds:
- configurable RAM read latency with a stall request;
- store byte-lane alignment and load sign/zero extension, both done internally;
- misaligned-access detection with write suppression;
- a debug port B.

## Interface
Parameters:
- ADDR_BITS, 12, word-address width; RAM depth is 2^ADDR_BITS 32-bit words.
- READ_LATENCY, 1, port-A read latency in cycles; legal range 1..4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  WB register enable; 0 = stall (hold).
- clear  in  1  WB register flush; takes effect when the register is allowed to update (same as a normal update).
- A  in  32  byte address from MEM (ALU result).
- WD  in  32  store data, unaligned (value in low bits).
- Funct3M  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- MemReadM  in  1  load in MEM.
- MemWriteM  in  1  store in MEM.
- ResultM  in  32  ALU/PC result.
- RdM  in  5  destination register.
- RegWriteM  in  1  register write enable.
- MemToRegM  in  1  WB mux select.
- ResultW  out  32  registered ResultM.
- RdW  out  5  registered RdM.
- RegWriteW  out  1  registered RegWriteM; forced 0 on a misaligned load.
- MemToRegW  out  1  registered MemToRegM.
- LoadDataW  out  32  extended load data.
- MisalignW  out  1  registered misaligned-access flag.
- MemBusy  out  1  stall request to the hazard unit.
- A2  in  32  debug byte address.
- WD2  in  32  debug write data.
- WE2  in  4  debug per-byte write enable (raw lanes).
- RD2  out  32  debug read data, 1-cycle latency.

## Operation
- **Update condition.** `upd = en & ~MemBusy`.
  - On `upd`, the registers ResultW, RdW, RegWriteW, MemToRegW, MisalignW, the internal Funct3W and the internal OffW (= A[1:0]) load their M-stage values, or zero if `clear`.
  - Otherwise they hold.
- **Misalignment.** Mis = (MemReadM | MemWriteM) & ((H/HU/SH & A[0]) | (W & A[1:0]≠0)).
  - A misaligned store writes nothing.
  - A misaligned load captures RegWriteW=0.
- **Stores.** Lane mask B = 0001 << A[1:0], H = 0011 << A[1:0], W = 1111. Data is WD replicated per width (B: {4{WD[7:0]}}, H: {2{WD[15:0]}}).
  - The write occurs at the edge where `MemWriteM & upd & ~clear & ~Mis`.
  - Address is A[ADDR_BITS+1:2]. Upper address bits are ignored (wrap).
- **Load latency FSM** (active only when READ_LATENCY>1), with a counter `cnt`:
  - States: IDLE, WAIT.
  - IDLE: MemBusy = MemReadM & en & ~clear & ~Mis. If MemBusy: go to WAIT, cnt←1.
  - WAIT: MemBusy = (cnt < READ_LATENCY−1). cnt increments each cycle while busy. When cnt = READ_LATENCY−1, MemBusy=0 and the WB capture occurs at that edge; then go to IDLE.
  - `clear` asserted in WAIT aborts: go to IDLE, MemBusy=0.
  - `en`=0 in WAIT freezes cnt.
  - The MEM-stage inputs are held stable by the hazard unit while MemBusy=1.
  - READ_LATENCY=1: MemBusy is constant 0 and the FSM is absent.
- **Load data path.** RD_raw is the port-A read result, valid in the cycle after the WB capture.
  - If the previous cycle had no update (`en` low): output the held copy of the last RD_raw.
  - Else if the previous update was a clear: raw = 0.
  - Extension uses Funct3W/OffW:
    - B: sign-extend byte OffW.
    - BU: zero-extend byte OffW.
    - H: sign-extend half OffW[1].
    - HU: zero-extend half OffW[1].
    - W: pass through.
  - LoadDataW is 0 when MisalignW=1.
- **Debug port B.** Independent of en/clear/rst. Word address A2[ADDR_BITS+1:2], byte writes per WE2. Same-address A/B write collision: port A wins.

## Timing
- **Reset.** Every output register is 0, FSM in IDLE, cnt=0, held RD copy = 0, MemBusy=0, LoadDataW=0. The RAM contents are not reset.
- **Store.** Data is visible to a load issued in the next MEM cycle (read-after-write through the RAM, no bypass needed).
- **Load.** The WB capture edge occurs READ_LATENCY−1 cycles after the load first appears in MEM; LoadDataW is valid in the following cycle.
- **Simultaneous events.**
  - rst beats everything.
  - clear beats en=0 only if `upd`; with en=0 everything holds, including clear.
  - A store in IDLE never raises MemBusy.

## Test plan
- **Legacy equivalence.** READ_LATENCY=1: SW 0x8000_00F1 to 0x10, then LB from 0x10 → LoadDataW=0xFFFF_FFF1, MemBusy never 1.
- **Lane alignment and extension.** SH 0x1234_ABCD to 0x22, then LW from 0x20 → 0xABCD_xxxx with the lower half unchanged; LHU from 0x22 → 0x0000_ABCD.
- **Busy length.** READ_LATENCY=3: LW from 0x40 → MemBusy high exactly 2 cycles; LoadDataW equals the stored word one cycle after the capture.
- **Stall and flush.** en=0 for 3 cycles after a load → LoadDataW holds; clear on the following update → all W outputs 0 next cycle.
- **Misaligned access.** SW to 0x41 → RAM unchanged, MisalignW=1; LH from 0x43 → RegWriteW=0, LoadDataW=0.
- **Reset mid-operation.** rst during WAIT → next cycle MemBusy=0, FSM IDLE, all outputs 0; a write via A2/WE2=1111 then a read via A2 → RD2 returns the data one cycle later.
